// File: rtl/hdmi_tx_int_service_pkg.sv
// Shared types and constants for the HDMI TX interrupt servicer.
// Holds the FSM state encoding, transmitter register map, CSR offsets and capture bit indices.
// Also holds the register-access command record and the helpers that build it.
package hdmi_tx_int_service_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_STAT,
        W_STAT,
        WR_CLR,
        W_CLR,
        RD_HPD,
        W_HPD,
        WR_PWR,
        W_PWR,
        HOLD
    } state_t;

    // Transmitter register map
    localparam logic [7:0] REG_INT_STAT = 8'h96;
    localparam logic [7:0] REG_HPD      = 8'h42;
    localparam logic [7:0] REG_PWR      = 8'h41;
    localparam int         HPD_BIT      = 6;

    // CSR word offsets
    localparam logic [1:0] CSR_STATUS  = 2'd0;
    localparam logic [1:0] CSR_CTRL    = 2'd1;
    localparam logic [1:0] CSR_MASK    = 2'd2;
    localparam logic [1:0] CSR_CAPTURE = 2'd3;

    // Capture / mask bit indices
    localparam int CAP_DONE = 0;
    localparam int CAP_HPD  = 1;
    localparam int CAP_ERR  = 2;

    // One register-access request as presented on the cmd_* port
    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    function automatic cmd_t rd_cmd(input logic [7:0] addr);
        rd_cmd = '{write: 1'b0, addr: addr, wdata: 8'h00};
    endfunction

    function automatic cmd_t wr_cmd(input logic [7:0] addr, input logic [7:0] wdata);
        wr_cmd = '{write: 1'b1, addr: addr, wdata: wdata};
    endfunction

    // States that wait for a response from the register-access master
    function automatic logic is_wait(input state_t s);
        is_wait = (s == W_STAT) || (s == W_CLR) || (s == W_HPD) || (s == W_PWR);
    endfunction

endpackage

// File: rtl/hdmi_tx_int_sync.sv
// Two-flop synchronizer for the asynchronous active-low int_n pad; resets to 1 (deasserted).
// Latency: 2 clk cycles from pad to int_n_sync.
// Backpressure: none, free-running.
// Ports: clk, reset_n (async active-low), int_n (raw pad), int_n_sync (synchronized level).
module hdmi_tx_int_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic int_n,
    output logic int_n_sync
);

    logic int_n_meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_n_meta <= 1'b1;
            int_n_sync <= 1'b1;
        end else begin
            int_n_meta <= int_n;
            int_n_sync <= int_n_meta;
        end
    end

endmodule

// File: rtl/hdmi_tx_int_service.sv
// Services the HDMI TX interrupt: reads/clears INT_STAT, re-reads HPD, optionally re-powers the TX.
// Latency: service starts 3 cycles after int_n falls; CSR reads return 1 cycle after address.
// Backpressure: cmd_* held stable until cmd_ready; one outstanding request; W_* states wait for rsp_valid.
//
// Ports: clk/reset_n (async active-low); int_n pad; Avalon-MM CSR slave (address, chipselect,
// write_n, writedata, readdata, irq); register-access master port (cmd_valid/cmd_ready,
// cmd_write, cmd_reg, cmd_wdata, rsp_valid, rsp_rdata, rsp_error); hpd status.
// Build option: define HDMI_TX_INT_SERVICE_TIMEOUT_EN to add a response watchdog to the W_* states.
module hdmi_tx_int_service
    import hdmi_tx_int_service_pkg::*;
#(
    parameter int unsigned RETRY_CYCLES   = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  PWR_UP_VAL     = 8'h10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        int_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    input  logic        rsp_error,
    output logic        hpd
);

    localparam int HOLD_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RETRY_CYCLES - 1);

    state_t            state;
    cmd_t              cmd_q;
    logic              int_n_sync;
    logic              int_act;
    logic              enable;
    logic              auto_pwr;
    logic [2:0]        mask;
    logic [2:0]        capture;
    logic [2:0]        cap_set;
    logic [2:0]        cap_clr;
    logic [7:0]        last_stat;
    logic              err;
    logic              busy;
    logic [HOLD_W-1:0] hold_cnt;
    logic              wait_st;
    logic              timeout_hit;
    logic              rsp_ok;
    logic              rsp_fail;
    logic              new_hpd;
    logic              pwr_needed;
    logic              svc_done;
    logic              csr_wr;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    hdmi_tx_int_sync u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .int_n      (int_n),
        .int_n_sync (int_n_sync)
    );

    assign int_act   = ~int_n_sync;
    assign busy      = (state != IDLE);
    assign irq       = |(capture & mask);
    assign cmd_write = cmd_q.write;
    assign cmd_reg   = cmd_q.addr;
    assign cmd_wdata = cmd_q.wdata;

    // Only the low CSR bits are implemented.
    assign unused_wdata = ^writedata[31:3];

`ifdef HDMI_TX_INT_SERVICE_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;

    // Counts cycles spent in a W_* state; restarts on every new wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (!wait_st || rsp_valid) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // A response arriving on the last cycle still counts as a response.
    assign timeout_hit = wait_st && !rsp_valid && (to_cnt == TO_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        wait_st    = is_wait(state);
        csr_wr     = chipselect && !write_n;
        new_hpd    = rsp_rdata[HPD_BIT];
        rsp_ok     = wait_st && rsp_valid && !rsp_error;
        rsp_fail   = wait_st && ((rsp_valid && rsp_error) || timeout_hit);
        // Re-power only on a fresh plug-in, not on every interrupt with HPD high.
        pwr_needed = auto_pwr && new_hpd && (new_hpd != hpd);
        svc_done   = rsp_ok && (((state == W_HPD) && !pwr_needed) || (state == W_PWR));

        cap_set           = '0;
        cap_set[CAP_DONE] = svc_done;
        cap_set[CAP_HPD]  = rsp_ok && (state == W_HPD) && (new_hpd != hpd);
        cap_set[CAP_ERR]  = rsp_fail;

        cap_clr = '0;
        if (csr_wr && (address == CSR_CAPTURE)) begin
            cap_clr = writedata[2:0];
        end

        rd_mux = '0;
        case (address)
            CSR_STATUS:  rd_mux = {21'b0, err, hpd, busy, last_stat};
            CSR_CTRL:    rd_mux = {30'b0, auto_pwr, enable};
            CSR_MASK:    rd_mux = {29'b0, mask};
            CSR_CAPTURE: rd_mux = {29'b0, capture};
            default:     rd_mux = '0;
        endcase
    end

    // CSR block
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            auto_pwr <= 1'b0;
            mask     <= '0;
            capture  <= '0;
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
            if (csr_wr && (address == CSR_CTRL)) begin
                enable   <= writedata[0];
                auto_pwr <= writedata[1];
            end
            if (csr_wr && (address == CSR_MASK)) begin
                mask <= writedata[2:0];
            end
            // Set events win over a simultaneous write-1-to-clear.
            capture <= (capture & ~cap_clr) | cap_set;
        end
    end

    // Service FSM. cmd_valid is raised together with the state entering a request
    // state and dropped on acceptance, so cmd_* are stable while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_q     <= '0;
            last_stat <= '0;
            err       <= 1'b0;
            hpd       <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && int_act) begin
                        state     <= RD_STAT;
                        cmd_valid <= 1'b1;
                        cmd_q     <= rd_cmd(REG_INT_STAT);
                    end
                end
                RD_STAT: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= W_STAT;
                    end
                end
                W_STAT: begin
                    if (rsp_ok) begin
                        last_stat <= rsp_rdata;
                        state     <= WR_CLR;
                        cmd_valid <= 1'b1;
                        cmd_q     <= wr_cmd(REG_INT_STAT, rsp_rdata);
                    end
                end
                WR_CLR: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= W_CLR;
                    end
                end
                W_CLR: begin
                    if (rsp_ok) begin
                        state     <= RD_HPD;
                        cmd_valid <= 1'b1;
                        cmd_q     <= rd_cmd(REG_HPD);
                    end
                end
                RD_HPD: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= W_HPD;
                    end
                end
                W_HPD: begin
                    if (rsp_ok) begin
                        hpd <= new_hpd;
                        if (pwr_needed) begin
                            state     <= WR_PWR;
                            cmd_valid <= 1'b1;
                            cmd_q     <= wr_cmd(REG_PWR, PWR_UP_VAL);
                        end else begin
                            state <= IDLE;
                            err   <= 1'b0;
                        end
                    end
                end
                WR_PWR: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= W_PWR;
                    end
                end
                W_PWR: begin
                    if (rsp_ok) begin
                        state <= IDLE;
                        err   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A failed or timed-out response abandons the sequence and backs off.
            if (rsp_fail) begin
                err      <= 1'b1;
                hold_cnt <= HOLD_LOAD;
                state    <= HOLD;
            end
        end
    end

endmodule

// File: doc/hdmi_tx_int_service.md
Name: hdmi_tx_int_service

Overview:
Hardware servicer for the HDMI transmitter's active-low interrupt pin. On an asserted interrupt it reads and clears the transmitter's interrupt status over a shared register-access (I2C master) command port, then re-reads hot-plug state and optionally re-powers the TX. It exposes a small Avalon-MM CSR slave with IRQ mask and edge capture to the Nios side. It sits between the int_n pad, the I2C master and the CPU interconnect.

Parameters:
RETRY_CYCLES, 1024, holdoff cycles after a failed transaction before retrying service.
TIMEOUT_CYCLES, 65535, max cycles waiting for rsp_valid (used only with the optional feature).
PWR_UP_VAL, 8'h10, value written to power register 0x41 on hot-plug.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
int_n  in  1  transmitter interrupt pin, active low, asynchronous
address  in  2  CSR word address
chipselect  in  1  CSR select
write_n  in  1  CSR write strobe, active low
writedata  in  32  CSR write data
readdata  out  32  CSR read data, registered
irq  out  1  CPU interrupt, active high
cmd_valid  out  1  register-access request valid
cmd_ready  in  1  I2C master accepts request
cmd_write  out  1  1=write, 0=read
cmd_reg  out  8  transmitter register address
cmd_wdata  out  8  write data
rsp_valid  in  1  one-cycle response strobe
rsp_rdata  in  8  read data
rsp_error  in  1  NACK/bus error, qualified by rsp_valid
hpd  out  1  last sampled hot-plug state

Behaviour:
- Reset: all outputs 0. Registers: state=IDLE, ctrl=0, mask=0, capture=0, last_stat=0, err=0, hpd=0.
- int_n passes through a 2-flop synchronizer with reset value 1 (deasserted). int_act = ~sync_int_n.
- CSR 0 (read): {21'b0, err, hpd, busy, last_stat[7:0]}.
- CSR 1 (rw): bit0 enable, bit1 auto_pwr.
- CSR 2 (rw): irq mask[2:0].
- CSR 3 (read): capture[2:0]. Write-1-to-clear per bit.
- readdata registers the mux every cycle: 1-cycle read latency, unmapped bits 0.
- capture bits: bit0 service done, bit1 hpd changed, bit2 error. A set event wins over a clear in the same cycle.
- irq = |(capture & mask), combinational.
- FSM states: IDLE, RD_STAT, W_STAT, WR_CLR, W_CLR, RD_HPD, W_HPD, WR_PWR, W_PWR, HOLD.
  - IDLE -> RD_STAT when enable && int_act (level-sensitive). busy=1 in every state except IDLE.
  - RD_STAT: cmd_valid=1, read reg 0x96. Go to W_STAT on cmd_ready.
  - W_STAT: on rsp_valid, latch last_stat=rsp_rdata, go to WR_CLR.
  - WR_CLR: write last_stat back to 0x96 (W1C). Go to W_CLR on cmd_ready.
  - W_CLR -> RD_HPD.
  - RD_HPD: read reg 0x42. In W_HPD, new_hpd = rsp_rdata[6]. If new_hpd != hpd, set capture[1]. hpd <= new_hpd.
  - From W_HPD: go to WR_PWR if auto_pwr && new_hpd && hpd changed; otherwise finish.
  - WR_PWR: write PWR_UP_VAL to 0x41. Go to W_PWR on cmd_ready.
  - W_PWR: on response, finish.
  - Finish: set capture[0], go to IDLE. If int_n is still low, service restarts the next cycle.
- cmd_* hold stable while cmd_valid && !cmd_ready. cmd_valid deasserts the cycle after acceptance. At most one outstanding request.
- Any rsp_valid with rsp_error: set err and capture[2], go to HOLD. Counter loads RETRY_CYCLES-1, decrements to 0, then goes to IDLE. The err bit clears when a service completes cleanly.
- Clearing enable mid-sequence: the current sequence completes (no abandoned I2C transaction). No new service starts.
- rsp_valid outside a W_* state is ignored.
- Asynchronous reset mid-sequence returns to IDLE immediately. The I2C master is reset by the same reset_n.

Optional Feature:
HDMI_TX_INT_SERVICE_TIMEOUT_EN
- Defined: each W_* state runs a 16-bit counter. Reaching TIMEOUT_CYCLES without rsp_valid is treated exactly as rsp_error (err, capture[2], HOLD).
- Undefined: W_* states wait indefinitely and the counter is not instantiated.

Decomposition:
- Package hdmi_tx_int_service_pkg holds:
  - state enum;
  - register constants REG_INT_STAT=8'h96, REG_HPD=8'h42, REG_PWR=8'h41, HPD_BIT=6;
  - CSR offsets 0-3 and capture bit indices.
- One sub-module, hdmi_tx_int_sync: a 2-flop reset-to-1 synchronizer.

Test Plan:
- int_n low, enable=1, cmd_ready=1, rsp_rdata 8'h84 then 8'h40 -> commands issued in order: rd 0x96, wr 0x96=0x84, rd 0x42. hpd=1, capture=3'b011, CSR0[7:0]=0x84.
- Same as above with auto_pwr=1 -> extra write 0x41=0x10. Then irq=1 with mask=1 and stays high until CSR3 is written with 1.
- cmd_ready held low 20 cycles -> cmd_valid, cmd_reg and cmd_write stable throughout. Exactly one request is accepted.
- rsp_error on the first read -> capture[2]=1, err=1, no write issued, busy for RETRY_CYCLES cycles, then retry while int_n is still low.
- enable cleared during W_STAT -> sequence completes, then IDLE with no restart despite int_n low.
- With macro defined, rsp_valid withheld -> error after TIMEOUT_CYCLES. With macro undefined, the block stays in W_STAT for 100k cycles.
